// File: rtl/inhibitory_spike_aer_tx.sv
// Address-event transmitter for the inhibitory layer.
// Captures one spike vector per accepted timestep and serialises the set
// indices, lowest first, over a valid/ready handshake. Also reports the
// frame popcount, a frame-done pulse and a sticky overrun flag.
module inhibitory_spike_aer_tx #(
  parameter int unsigned NUM_NEURONS = 100,
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned CNT_WIDTH   = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   step,
  input  logic [NUM_NEURONS-1:0] spike_vec,
  output logic                   busy,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [ADDR_WIDTH-1:0]  evt_addr,
  output logic                   evt_last,
  output logic                   frame_done,
  output logic [CNT_WIDTH-1:0]   spike_count,
  output logic                   overrun
);

  typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

  state_e                 state;
  logic [NUM_NEURONS-1:0] pending;
  logic [NUM_NEURONS-1:0] pending_rest;
  logic [CNT_WIDTH-1:0]   cap_count;
  logic [ADDR_WIDTH-1:0]  low_idx;
  logic                   last_evt;
  logic                   accept;

  // A new frame can only be taken when nothing is left to emit.
  assign accept = en && step && (state != StEmit);

  // Popcount of the incoming spike vector, loaded on capture.
  always_comb begin
    cap_count = '0;
    for (int i = 0; i < int'(NUM_NEURONS); i++) begin
      cap_count = cap_count + CNT_WIDTH'(spike_vec[i]);
    end
  end

  // Priority encoder: index of the lowest set pending bit (0 when empty).
  always_comb begin
    low_idx = '0;
    for (int i = int'(NUM_NEURONS) - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = ADDR_WIDTH'(i);
    end
  end

  // Clearing the lowest set bit; the event is last when nothing remains after it.
  always_comb begin
    pending_rest = pending & (pending - NUM_NEURONS'(1));
    last_evt     = (pending != '0) && (pending_rest == '0);
  end

  // Frame FSM with the pending vector, frame count and overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      pending     <= '0;
      spike_count <= '0;
      overrun     <= 1'b0;
    end else begin
      if (accept) begin
        pending     <= spike_vec;
        spike_count <= cap_count;
        state       <= (spike_vec != '0) ? StEmit : StDone;
      end else begin
        case (state)
          StIdle: state <= StIdle;
          StEmit: begin
            if (evt_ready) begin
              pending <= pending_rest;
              if (last_evt) state <= StDone;
            end
          end
          StDone:  state <= StIdle;
          default: state <= StIdle;
        endcase
      end
      // A step during emission is dropped but remembered until reset.
      if (en && step && (state == StEmit)) overrun <= 1'b1;
    end
  end

  // Outputs decode directly from registered state and the pending vector only.
  always_comb begin
    evt_valid  = (state == StEmit);
    busy       = (state == StEmit);
    frame_done = (state == StDone);
    evt_addr   = low_idx;
    evt_last   = last_evt;
  end

endmodule

// File: tb/tb_inhibitory_spike_aer_tx.sv
// Self-checking bench for inhibitory_spike_aer_tx: a scoreboard queue holds
// expected events, popped by a monitor on every observed handshake.
module tb_inhibitory_spike_aer_tx;

  localparam int unsigned N  = 100;
  localparam int unsigned AW = 7;
  localparam int unsigned CW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          step;
  logic [N-1:0]  spike_vec;
  logic          busy;
  logic          evt_valid;
  logic          evt_ready;
  logic [AW-1:0] evt_addr;
  logic          evt_last;
  logic          frame_done;
  logic [CW-1:0] spike_count;
  logic          overrun;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned hs_cnt = 0;
  int unsigned fd_cnt = 0;
  int unsigned sb[$];
  int unsigned e;

  inhibitory_spike_aer_tx #(
    .NUM_NEURONS(N),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .step       (step),
    .spike_vec  (spike_vec),
    .busy       (busy),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_addr   (evt_addr),
    .evt_last   (evt_last),
    .frame_done (frame_done),
    .spike_count(spike_count),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp_v);
    n_chk++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (evt_valid && evt_ready) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_evt", 32'(evt_addr), 999);
      end else begin
        e = sb.pop_front();
        check("evt_addr", 32'(evt_addr), e & 32'hff);
        check("evt_last", 32'(evt_last), e >> 8);
      end
    end
  end

  // Drive an accepted step and push the expected events of that frame.
  task automatic do_step(input logic [N-1:0] v);
    int hi;
    hi = -1;
    for (int i = 0; i < int'(N); i++) if (v[i]) hi = i;
    for (int i = 0; i < int'(N); i++) begin
      if (v[i]) sb.push_back(32'(i) | ((i == hi) ? 32'h100 : 32'h0));
    end
    spike_vec = v;
    en        = 1'b1;
    step      = 1'b1;
    tick();
    step      = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned fd0;
    int unsigned n;
    fd0 = fd_cnt;
    n   = 0;
    while (fd_cnt == fd0 && n < budget) begin
      tick();
      n++;
    end
    if (fd_cnt == fd0) check("frame_done_timeout", 0, 1);
  endtask

  initial begin
    logic [N-1:0] v;
    int unsigned  hs0;
    int unsigned  fd0;
    rst = 1'b1; en = 1'b0; step = 1'b0; spike_vec = '0; evt_ready = 1'b0;
    repeat (2) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_addr", 32'(evt_addr), 0);
    check("rst_last", 32'(evt_last), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_count", 32'(spike_count), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    tick();

    // Sparse frame with ready held high.
    evt_ready = 1'b1;
    v = '0; v[3] = 1'b1; v[17] = 1'b1; v[99] = 1'b1;
    hs0 = hs_cnt;
    do_step(v);
    check("sparse_count", 32'(spike_count), 3);
    check("sparse_valid_t1", 32'(evt_valid), 1);
    check("sparse_first_addr", 32'(evt_addr), 3);
    check("sparse_busy", 32'(busy), 1);
    repeat (3) tick();
    check("sparse_frame_done", 32'(frame_done), 1);
    check("sparse_busy_done", 32'(busy), 0);
    check("sparse_valid_done", 32'(evt_valid), 0);
    tick();
    check("sparse_fd_pulse", 32'(frame_done), 0);
    check("sparse_hs", hs_cnt - hs0, 3);
    check("sparse_sb_empty", sb.size(), 0);

    // Backpressure: four stalled cycles on the first event.
    evt_ready = 1'b0;
    hs0 = hs_cnt;
    do_step(v);
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", 32'(evt_valid), 1);
      check("stall_addr", 32'(evt_addr), 3);
      check("stall_last", 32'(evt_last), 0);
      tick();
    end
    evt_ready = 1'b1;
    wait_done(20);
    check("stall_hs", hs_cnt - hs0, 3);
    check("stall_sb_empty", sb.size(), 0);
    tick();

    // Empty frame, then a step with en low.
    do_step('0);
    check("empty_frame_done", 32'(frame_done), 1);
    check("empty_valid", 32'(evt_valid), 0);
    check("empty_count", 32'(spike_count), 0);
    tick();
    check("empty_fd_pulse", 32'(frame_done), 0);
    v = '0; v[7] = 1'b1;
    spike_vec = v; en = 1'b0; step = 1'b1;
    tick();
    step = 1'b0; en = 1'b1;
    check("en0_valid", 32'(evt_valid), 0);
    check("en0_busy", 32'(busy), 0);
    check("en0_count", 32'(spike_count), 0);
    check("en0_frame_done", 32'(frame_done), 0);
    check("en0_overrun", 32'(overrun), 0);

    // Overrun: second step while emitting is dropped.
    evt_ready = 1'b0;
    hs0 = hs_cnt;
    v = '0; v[5] = 1'b1;
    do_step(v);
    v = '0; v[6] = 1'b1;
    spike_vec = v; step = 1'b1;
    tick();
    step = 1'b0;
    check("ovr_set", 32'(overrun), 1);
    check("ovr_addr", 32'(evt_addr), 5);
    check("ovr_count", 32'(spike_count), 1);
    tick();
    check("ovr_sticky", 32'(overrun), 1);
    evt_ready = 1'b1;
    wait_done(20);
    check("ovr_hs", hs_cnt - hs0, 1);
    check("ovr_sb_empty", sb.size(), 0);
    check("ovr_still_set", 32'(overrun), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ovr_rst_clear", 32'(overrun), 0);
    tick();

    // Full vector, then back-to-back step accepted in the DONE cycle.
    hs0 = hs_cnt;
    do_step('1);
    check("full_count", 32'(spike_count), 100);
    for (int i = 0; i < 200 && frame_done == 1'b0; i++) tick();
    check("full_reached_done", 32'(frame_done), 1);
    check("full_hs", hs_cnt - hs0, 100);
    v = '0; v[0] = 1'b1;
    do_step(v);
    check("b2b_valid", 32'(evt_valid), 1);
    check("b2b_addr", 32'(evt_addr), 0);
    check("b2b_last", 32'(evt_last), 1);
    check("b2b_count", 32'(spike_count), 1);
    tick();
    check("b2b_frame_done", 32'(frame_done), 1);
    check("b2b_sb_empty", sb.size(), 0);
    tick();

    // Reset after two of five events.
    hs0 = hs_cnt;
    v = '0; v[1] = 1'b1; v[2] = 1'b1; v[4] = 1'b1; v[8] = 1'b1; v[9] = 1'b1;
    do_step(v);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    while (sb.size() > 0) void'(sb.pop_front());
    fd0 = fd_cnt;
    check("mid_rst_hs", hs_cnt - hs0, 2);
    check("mid_rst_valid", 32'(evt_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_addr", 32'(evt_addr), 0);
    check("mid_rst_last", 32'(evt_last), 0);
    check("mid_rst_count", 32'(spike_count), 0);
    repeat (3) tick();
    check("mid_rst_no_fd", fd_cnt - fd0, 0);
    check("mid_rst_idle_valid", 32'(evt_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inhibitory_spike_aer_tx.md
Name: inhibitory_spike_aer_tx

Overview:
- Address-event (AER) transmitter for the inhibitory layer.
- Each timestep it captures the parallel spike_out vector of all inhibitory neurons and serialises the active indices, lowest index first, as address events over a valid/ready handshake.
- The downstream excitatory layer consumes these events as lateral-inhibition input.
- Also reports the spike count per frame, a frame-done pulse and a sticky overrun flag.

Parameters:
NUM_NEURONS, 100, number of inhibitory neurons (spike vector width)
ADDR_WIDTH, 7, width of event address; must satisfy 2**ADDR_WIDTH >= NUM_NEURONS
CNT_WIDTH, 7, width of spike_count; must hold NUM_NEURONS

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  capture enable; gates acceptance of step only
step  in  1  timestep strobe; capture spike_vec when accepted
spike_vec  in  NUM_NEURONS  spike_out bits of inhibitory neurons, bit i = neuron i
busy  out  1  high while a frame is pending or being emitted
evt_valid  out  1  event available
evt_ready  in  1  downstream accepts event
evt_addr  out  ADDR_WIDTH  index of spiking neuron
evt_last  out  1  current event is last of frame
frame_done  out  1  one-cycle pulse after frame completes
spike_count  out  CNT_WIDTH  popcount of last captured frame
overrun  out  1  sticky: step arrived while busy

Behaviour:
- Reset values: state IDLE, pending register 0, busy 0, evt_valid 0, evt_addr 0, evt_last 0, frame_done 0, spike_count 0, overrun 0.
- States: IDLE, EMIT, DONE. A step is accepted when en=1, step=1 and state is IDLE or DONE.
- Capture at clock edge t:
  - pending <= spike_vec; spike_count <= popcount(spike_vec).
  - If spike_vec != 0: go to EMIT. evt_valid is high from cycle t+1.
  - If spike_vec == 0: go to DONE. frame_done is high at cycle t+1 and no event is emitted.
- EMIT:
  - evt_valid=1.
  - evt_addr = index of lowest set bit of pending.
  - evt_last=1 iff exactly one bit of pending is set.
  - evt_addr and evt_last are registered or derived from pending only. They must stay stable while evt_valid=1 and evt_ready=0.
  - On evt_valid && evt_ready: clear that bit of pending. The next event (next lowest bit) is presented the following cycle with no bubble.
  - With evt_ready held high, one event is transferred per cycle.
  - After the handshake with evt_last=1: go to DONE, evt_valid=0.
- DONE:
  - frame_done=1 for exactly that one cycle.
  - Next state: IDLE, or EMIT/DONE if a step is accepted in the same cycle (back-to-back frames).
- busy=1 in EMIT; busy=0 in IDLE and DONE.
- Overrun: if step=1 and en=1 while in EMIT, the step is dropped and overrun is set sticky. pending is unchanged. Only rst clears overrun.
- en=0: step is ignored, with no overrun and no capture. An in-flight frame continues emitting regardless of en.
- spike_count holds its value until the next accepted capture.
- evt_ready while evt_valid=0 has no effect.
- rst mid-frame: all pending events are discarded. evt_valid drops on the next cycle and no frame_done is produced.
- Bits of spike_vec above NUM_NEURONS-1 do not exist. evt_addr upper bits are zero-extended.
- No combinational path from evt_ready to evt_valid, evt_addr or evt_last.

Test Plan:
- Sparse frame, ready held high: rst, then step with spike_vec bits {3,17,99} set. Required:
  - spike_count=3.
  - Events 3, 17, 99 on consecutive cycles starting at t+1; evt_last only on 99.
  - frame_done one cycle after the 99 handshake; busy low afterwards.
- Backpressure: same frame, evt_ready=0 for 4 cycles, then 1. Required:
  - evt_addr=3 and evt_valid=1 stable for all stalled cycles.
  - Exactly 3 handshakes; no duplicate or skipped address.
- Empty frame and en gating:
  - step with spike_vec=0 -> no evt_valid; frame_done pulse at t+1; spike_count=0.
  - step with en=0 -> nothing happens.
- Overrun: step with bit 5 set, ready=0, then a second step with bit 6 set while in EMIT. Required:
  - overrun=1 and stays 1.
  - Only address 5 is emitted after ready rises.
  - rst clears overrun to 0.
- Back-to-back and full vector:
  - step with all 100 bits set, ready=1 -> addresses 0..99 in order; spike_count=100.
  - A step with bit 0 set during the DONE cycle is accepted: address 0 is emitted next cycle with evt_last=1.
- Reset mid-frame: rst asserted after 2 of 5 events. Required:
  - evt_valid=0 the cycle after rst.
  - No frame_done; all outputs at reset values.
